// File: rtl/spi_ram_pkg.sv
// Shared types for the SPI-to-RAM command sequencer: rx word layout, command
// encodings and sequencer states.
package spi_ram_pkg;

    localparam int unsigned CMD_W  = 2;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned DIN_W  = CMD_W + DATA_W;

    typedef enum logic [CMD_W-1:0] {
        CMD_WR_ADDR = 2'b00,
        CMD_WR_DATA = 2'b01,
        CMD_RD_ADDR = 2'b10,
        CMD_RD_DATA = 2'b11
    } cmd_e;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        RD_WAIT = 2'b01,
        RD_RESP = 2'b10
    } state_e;

    // One rx word as delivered by the SPI slave: command in the top two bits.
    typedef struct packed {
        cmd_e              cmd;
        logic [DATA_W-1:0] payload;
    } rx_word_t;

    function automatic rx_word_t decode_word(input logic [DIN_W-1:0] w);
        return rx_word_t'(w);
    endfunction

endpackage

// File: rtl/spi_ram_ctrl_if.sv
// Link between the SPI slave (master side) and the RAM command sequencer.
interface spi_ram_ctrl_if
    import spi_ram_pkg::*;
;
    logic [DIN_W-1:0]  din;
    logic              rx_valid;
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              busy;
    logic              cmd_err;

    modport master (
        output din, rx_valid,
        input  tx_data, tx_valid, busy, cmd_err
    );

    modport slave (
        input  din, rx_valid,
        output tx_data, tx_valid, busy, cmd_err
    );
endinterface

// File: rtl/spi_sp_ram.sv
// Synchronous single-port RAM with a registered read port (one-cycle latency).
module spi_sp_ram #(
    parameter int unsigned MEM_DEPTH = 256,
    parameter int unsigned ADDR_SIZE = 8,
    parameter int unsigned DATA_W    = 8
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [ADDR_SIZE-1:0] addr,
    input  logic [DATA_W-1:0]    wdata,
    output logic [DATA_W-1:0]    rdata
);

    logic [DATA_W-1:0] mem [MEM_DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/spi_ram_ctrl.sv
// Command sequencer between the SPI slave and an on-chip single-port RAM.
// Define SPI_RAM_AUTOINC_EN to post-increment wr_addr/rd_addr after each access.
module spi_ram_ctrl
    import spi_ram_pkg::*;
#(
    parameter int unsigned MEM_DEPTH = 256,
    parameter int unsigned ADDR_SIZE = 8
) (
    input  logic           clk,
    input  logic           rst,
    spi_ram_ctrl_if.slave  bus
);

    rx_word_t             word;
    state_e               state;
    state_e               next_state;

    logic [ADDR_SIZE-1:0] wr_addr;
    logic [ADDR_SIZE-1:0] wr_addr_d;
    logic [ADDR_SIZE-1:0] rd_addr;
    logic [ADDR_SIZE-1:0] rd_addr_d;
    logic                 rd_addr_set;
    logic                 rd_addr_set_d;
    logic                 rd_unset;
    logic                 rd_unset_d;

    logic [DATA_W-1:0]    tx_data_d;
    logic                 tx_valid_d;
    logic                 busy_d;
    logic                 cmd_err_d;

    logic                 ram_we;
    logic [ADDR_SIZE-1:0] ram_addr;
    logic [DATA_W-1:0]    ram_rdata;

    assign word = decode_word(bus.din);

    spi_sp_ram #(
        .MEM_DEPTH (MEM_DEPTH),
        .ADDR_SIZE (ADDR_SIZE),
        .DATA_W    (DATA_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (word.payload),
        .rdata (ram_rdata)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: only a read command leaves IDLE
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                if (bus.rx_valid && (word.cmd == CMD_RD_DATA)) begin
                    next_state = RD_WAIT;
                end
            end
            RD_WAIT: next_state = RD_RESP;
            RD_RESP: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Output / datapath logic; words arriving while busy are dropped and flagged
    always_comb begin
        wr_addr_d     = wr_addr;
        rd_addr_d     = rd_addr;
        rd_addr_set_d = rd_addr_set;
        rd_unset_d    = rd_unset;
        tx_data_d     = bus.tx_data;
        tx_valid_d    = 1'b0;
        busy_d        = (next_state != IDLE);
        cmd_err_d     = bus.rx_valid && (state != IDLE);
        ram_we        = 1'b0;
        ram_addr      = wr_addr;

        unique case (state)
            IDLE: begin
                if (bus.rx_valid) begin
                    unique case (word.cmd)
                        CMD_WR_ADDR: begin
                            wr_addr_d = word.payload[ADDR_SIZE-1:0];
                        end
                        CMD_WR_DATA: begin
                            ram_we   = 1'b1;
                            ram_addr = wr_addr;
`ifdef SPI_RAM_AUTOINC_EN
                            wr_addr_d = ADDR_SIZE'(wr_addr + 1'b1);
`endif
                        end
                        CMD_RD_ADDR: begin
                            rd_addr_d     = word.payload[ADDR_SIZE-1:0];
                            rd_addr_set_d = 1'b1;
                        end
                        CMD_RD_DATA: begin
                            ram_addr   = rd_addr;
                            rd_unset_d = ~rd_addr_set;
                        end
                        default: ;
                    endcase
                end
            end
            RD_WAIT: begin
                // RAM output for rd_addr is valid this cycle
                tx_data_d  = ram_rdata;
                tx_valid_d = 1'b1;
                cmd_err_d  = cmd_err_d | rd_unset;
            end
            RD_RESP: begin
`ifdef SPI_RAM_AUTOINC_EN
                rd_addr_d = ADDR_SIZE'(rd_addr + 1'b1);
`endif
            end
            default: ;
        endcase
    end

    // Registered outputs and address state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_addr      <= '0;
            rd_addr      <= '0;
            rd_addr_set  <= 1'b0;
            rd_unset     <= 1'b0;
            bus.tx_data  <= '0;
            bus.tx_valid <= 1'b0;
            bus.busy     <= 1'b0;
            bus.cmd_err  <= 1'b0;
        end else begin
            wr_addr      <= wr_addr_d;
            rd_addr      <= rd_addr_d;
            rd_addr_set  <= rd_addr_set_d;
            rd_unset     <= rd_unset_d;
            bus.tx_data  <= tx_data_d;
            bus.tx_valid <= tx_valid_d;
            bus.busy     <= busy_d;
            bus.cmd_err  <= cmd_err_d;
        end
    end

endmodule
